pipe_hazard_latch: RTL and testbench
====================================

# pipe_hazard_latch

Builds the 32-bit bypass words for the D/X, X/M and M/W pipeline latches from decode-stage instruction fields and advances them in lockstep with the datapath. Its registered outputs DXB, XMB and MWB feed the bypass/forwarding unit. It also generates the pipeline stall for load-use hazards and multdiv occupancy, inserting bubbles and applying branch flushes.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- fd_valid  in  1  F/D latch holds a real instruction
- fd_rs_a  in  5  decode read register A
- fd_rs_b  in  5  decode read register B
- fd_rd  in  5  decode destination register
- fd_wen  in  1  decode instruction writes the register file
- fd_lw  in  1  decode instruction is lw
- fd_sw  in  1  decode instruction is sw
- fd_wr30  in  1  decode instruction writes r30 (setx/exception status)
- flush  in  1  branch/jump taken, resolved in X; squash the decode instruction
- md_busy  in  1  multdiv operation in X not yet complete
- DXB  out  32  D/X bypass word
- XMB  out  32  X/M bypass word
- MWB  out  32  M/W bypass word
- stall  out  1  freeze PC and F/D latch this cycle
- lu_hazard  out  1  load-use hazard detected this cycle
- stall_count  out  CNT_W  number of cycles with stall=1

## Operation
- Word format: [4:0] readregA, [9:5] readregB, [14:10] regtowrite, [29] lw, [30] sw, [31] writeto30, [28:15] zero.
- Encode(fd), when fd_valid=1:
  - readregA = fd_rs_a; readregB = fd_rs_b.
  - regtowrite = 30 if fd_wr30, else fd_rd if fd_wen, else 0.
  - bit29 = fd_lw; bit30 = fd_sw; bit31 = fd_wr30.
- fd_valid=0 encodes as the all-zero bubble.
- lu_hazard is combinational: fd_valid & DXB[29] & (DXB[14:10]≠0) & (fd_rs_a==DXB[14:10] | (!fd_sw & fd_rs_b==DXB[14:10])).
  - sw store-data is exempt; it is covered by M/W data bypass.
- stall = lu_hazard | md_busy (combinational).
- Clock-edge update, priority high to low:
  - md_busy: DX holds; XM ← 0 (bubble); MW ← XM. flush is ignored (protocol violation, cannot co-occur).
  - flush: DX ← 0; XM ← DX; MW ← XM.
  - lu_hazard: DX ← 0 (bubble); XM ← DX; MW ← XM.
  - Otherwise: DX ← Encode(fd); XM ← DX; MW ← XM.
- stall_count increments on every edge where stall=1 and saturates at all-ones (no wrap).

## Timing
- Reset (asynchronous, immediate): DXB=XMB=MWB=0, stall_count=0.
  - stall and lu_hazard then follow their equations: both 0 unless md_busy=1.
- Latency, no stalls: fields presented in cycle n appear on DXB in n+1, XMB in n+2, MWB in n+3.
- Load-use costs exactly one bubble: the dependent instruction is held in F/D and enters DX one cycle late. In that cycle DXB is no longer lw, so lu_hazard clears.
- md_busy held k cycles:
  - DXB is constant for those k cycles.
  - k bubbles enter XM.
  - The multdiv word moves to XM on the first edge with md_busy=0.
- Reset mid-stall: all latches clear; stall_count restarts at 0.

## Test plan
- Reset check: assert reset mid-cycle, no clock edge → DXB/XMB/MWB=0 and stall_count=0 immediately.
- Flow-through: encode add r3←r1,r2 (fd_wen=1) → DXB=0x00000C41 next cycle, then XMB, then MWB on successive cycles.
- Load-use:
  - lw r5 then add r6←r5,r1 → lu_hazard=1 for one cycle; DXB=0 after that edge; add reaches DXB one cycle later; stall_count=1.
  - Same sequence with a sw using r5 only as readregB → no stall.
- Load to r0 then read r0 → lu_hazard=0.
- md_busy held 3 cycles with a mult in DX → DXB constant 3 cycles, XMB=0 for 3 cycles, mult word reaches XMB on the next edge; flush pulsed during busy has no effect.
- Flush: pulse flush with a valid decode instruction → DX ← 0, XM/MW still advance.
- Saturation: CNT_W=4 with stall held 20 cycles → stall_count stops at 15.
- setx: fd_wr30=1 with fd_rd=7 → DXB[14:10]=30, DXB[31]=1.

Source files
------------

// File: rtl/pipe_hazard_latch.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_latch
// Description : Builds the 32-bit bypass words for the D/X, X/M and M/W
//               pipeline latches from decode-stage fields and advances them in
//               lockstep with the datapath. Detects load-use hazards, combines
//               them with multdiv occupancy into the pipeline stall, inserts
//               bubbles and applies branch flushes. Counts stalled cycles with
//               a saturating counter.
//
//               Bypass word layout:
//                 [4:0]   readregA
//                 [9:5]   readregB
//                 [14:10] regtowrite (0 = no write)
//                 [28:15] zero
//                 [29]    lw
//                 [30]    sw
//                 [31]    writes r30
//
// Ports       : clock        - pipeline clock, rising edge
//               reset        - asynchronous active-high clear
//               fd_*         - decode-stage instruction fields
//               flush        - taken branch/jump, squash decode instruction
//               md_busy      - multdiv in X not yet complete
//               DXB/XMB/MWB  - registered bypass words
//               stall        - freeze PC and F/D latch
//               lu_hazard    - load-use hazard this cycle
//               stall_count  - saturating count of stalled cycles
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_latch #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fd_valid,
    input  logic [4:0]       fd_rs_a,
    input  logic [4:0]       fd_rs_b,
    input  logic [4:0]       fd_rd,
    input  logic             fd_wen,
    input  logic             fd_lw,
    input  logic             fd_sw,
    input  logic             fd_wr30,
    input  logic             flush,
    input  logic             md_busy,
    output logic [31:0]      DXB,
    output logic [31:0]      XMB,
    output logic [31:0]      MWB,
    output logic             stall,
    output logic             lu_hazard,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [4:0]       c_r30     = 5'd30;

    logic [31:0] w_enc;
    logic [4:0]  w_dx_rd;

    // Encode the decode-stage instruction; an invalid slot is the all-zero bubble.
    always_comb begin
        w_enc = '0;
        if (fd_valid) begin
            w_enc[4:0] = fd_rs_a;
            w_enc[9:5] = fd_rs_b;
            if (fd_wr30) begin
                w_enc[14:10] = c_r30;
            end else if (fd_wen) begin
                w_enc[14:10] = fd_rd;
            end
            w_enc[29] = fd_lw;
            w_enc[30] = fd_sw;
            w_enc[31] = fd_wr30;
        end
    end

    assign w_dx_rd = DXB[14:10];

    // A store's data operand (readregB) is exempt: the loaded value can be
    // forwarded from M/W in time for the memory write.
    assign lu_hazard = fd_valid & DXB[29] & (w_dx_rd != 5'd0) &
                       ((fd_rs_a == w_dx_rd) | (~fd_sw & (fd_rs_b == w_dx_rd)));

    assign stall = lu_hazard | md_busy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            DXB         <= '0;
            XMB         <= '0;
            MWB         <= '0;
            stall_count <= '0;
        end else begin
            if (md_busy) begin
                // Multdiv occupies X: hold it in DX, feed bubbles downstream.
                XMB <= '0;
                MWB <= XMB;
            end else if (flush || lu_hazard) begin
                DXB <= '0;
                XMB <= DXB;
                MWB <= XMB;
            end else begin
                DXB <= w_enc;
                XMB <= DXB;
                MWB <= XMB;
            end

            if (stall && (stall_count != c_cnt_max)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_latch
// Description : Directed bench for pipe_hazard_latch. The stimulus process
//               drives one instruction per cycle and queues the hand-computed
//               expected outputs; a monitor pops and compares on each falling
//               edge. A second instance with a 4-bit counter shares the
//               stimulus to observe saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_latch;

    typedef struct packed {
        logic       v;
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] rd;
        logic       wen;
        logic       lw;
        logic       sw;
        logic       wr30;
    } inst_t;

    typedef struct {
        int          id;
        logic [31:0] dx;
        logic [31:0] xm;
        logic [31:0] mw;
        logic        st;
        logic        lu;
        int          cnt;
    } exp_t;

    localparam inst_t NOP   = '0;
    localparam inst_t ADD3  = {1'b1, 5'd1, 5'd2,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0}; // 0x00000C41
    localparam inst_t LW5   = {1'b1, 5'd2, 5'd0,  5'd5,  1'b1, 1'b1, 1'b0, 1'b0}; // 0x20001402
    localparam inst_t ADD6  = {1'b1, 5'd5, 5'd1,  5'd6,  1'b1, 1'b0, 1'b0, 1'b0}; // 0x00001825
    localparam inst_t SW5B  = {1'b1, 5'd4, 5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0}; // 0x400000A4
    localparam inst_t LW0   = {1'b1, 5'd2, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0}; // 0x20000002
    localparam inst_t RD0   = {1'b1, 5'd0, 5'd0,  5'd7,  1'b1, 1'b0, 1'b0, 1'b0}; // 0x00001C00
    localparam inst_t MULT  = {1'b1, 5'd9, 5'd10, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0}; // 0x00002149
    localparam inst_t ADD11 = {1'b1, 5'd12, 5'd13, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0}; // 0x00002DAC
    localparam inst_t SETX  = {1'b1, 5'd0, 5'd0,  5'd7,  1'b0, 1'b0, 1'b0, 1'b1}; // 0x80007800

    logic        clock = 1'b0;
    logic        reset;
    logic        fd_valid, fd_wen, fd_lw, fd_sw, fd_wr30, flush, md_busy;
    logic [4:0]  fd_rs_a, fd_rs_b, fd_rd;
    logic [31:0] DXB, XMB, MWB, DXB4, XMB4, MWB4;
    logic        stall, lu_hazard, stall4, lu_hazard4;
    logic [15:0] stall_count;
    logic [3:0]  stall_count4;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    pipe_hazard_latch #(.CNT_W(16)) dut (
        .clock(clock), .reset(reset), .fd_valid(fd_valid), .fd_rs_a(fd_rs_a),
        .fd_rs_b(fd_rs_b), .fd_rd(fd_rd), .fd_wen(fd_wen), .fd_lw(fd_lw),
        .fd_sw(fd_sw), .fd_wr30(fd_wr30), .flush(flush), .md_busy(md_busy),
        .DXB(DXB), .XMB(XMB), .MWB(MWB), .stall(stall), .lu_hazard(lu_hazard),
        .stall_count(stall_count)
    );

    pipe_hazard_latch #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .fd_valid(fd_valid), .fd_rs_a(fd_rs_a),
        .fd_rs_b(fd_rs_b), .fd_rd(fd_rd), .fd_wen(fd_wen), .fd_lw(fd_lw),
        .fd_sw(fd_sw), .fd_wr30(fd_wr30), .flush(flush), .md_busy(md_busy),
        .DXB(DXB4), .XMB(XMB4), .MWB(MWB4), .stall(stall4), .lu_hazard(lu_hazard4),
        .stall_count(stall_count4)
    );

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL step%0d %s: got 0x%08h expected 0x%08h", id, name, act, req);
        end
    endtask

    // Monitor: compares whatever the stimulus queued for this cycle.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            int   c4;
            e  = exp_q.pop_front();
            c4 = (e.cnt > 15) ? 15 : e.cnt;
            chk("DXB",           e.id, DXB,                     e.dx);
            chk("XMB",           e.id, XMB,                     e.xm);
            chk("MWB",           e.id, MWB,                     e.mw);
            chk("stall",         e.id, {31'd0, stall},          {31'd0, e.st});
            chk("lu_hazard",     e.id, {31'd0, lu_hazard},      {31'd0, e.lu});
            chk("stall_count",   e.id, {16'd0, stall_count},    e.cnt);
            chk("stall_count4",  e.id, {28'd0, stall_count4},   c4);
        end
    end

    // One cycle: after the rising edge, drive this cycle's inputs and queue the
    // outputs expected before the next rising edge.
    task automatic step(input int id, input logic rst, input inst_t in, input logic fl,
                        input logic mb, input logic [31:0] dx, input logic [31:0] xm,
                        input logic [31:0] mw, input logic st, input logic lu, input int cnt);
        exp_t e;
        @(posedge clock);
        #1;
        reset    = rst;
        fd_valid = in.v;
        fd_rs_a  = in.a;
        fd_rs_b  = in.b;
        fd_rd    = in.rd;
        fd_wen   = in.wen;
        fd_lw    = in.lw;
        fd_sw    = in.sw;
        fd_wr30  = in.wr30;
        flush    = fl;
        md_busy  = mb;
        e.id = id; e.dx = dx; e.xm = xm; e.mw = mw; e.st = st; e.lu = lu; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        {fd_valid, fd_rs_a, fd_rs_b, fd_rd, fd_wen, fd_lw, fd_sw, fd_wr30} = NOP;
        flush   = 1'b0;
        md_busy = 1'b0;

        //    id rst inst   fl  mb   DXB           XMB           MWB           st lu cnt
        // flow-through of add r3<-r1,r2
        step(1,  0, ADD3,  0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0);
        step(2,  0, NOP,   0, 0, 32'h00000C41, 32'h0,        32'h0,        0, 0, 0);
        step(3,  0, NOP,   0, 0, 32'h0,        32'h00000C41, 32'h0,        0, 0, 0);
        // lw r5 then dependent add r6<-r5,r1: one bubble
        step(4,  0, LW5,   0, 0, 32'h0,        32'h0,        32'h00000C41, 0, 0, 0);
        step(5,  0, ADD6,  0, 0, 32'h20001402, 32'h0,        32'h0,        1, 1, 0);
        step(6,  0, ADD6,  0, 0, 32'h0,        32'h20001402, 32'h0,        0, 0, 1);
        // lw r5 then sw using r5 only as store data: no stall
        step(7,  0, LW5,   0, 0, 32'h00001825, 32'h0,        32'h20001402, 0, 0, 1);
        step(8,  0, SW5B,  0, 0, 32'h20001402, 32'h00001825, 32'h0,        0, 0, 1);
        // load to r0 then read r0: no hazard
        step(9,  0, LW0,   0, 0, 32'h400000A4, 32'h20001402, 32'h00001825, 0, 0, 1);
        step(10, 0, RD0,   0, 0, 32'h20000002, 32'h400000A4, 32'h20001402, 0, 0, 1);
        // mult held by md_busy for 3 edges, flush pulsed during busy
        step(11, 0, MULT,  0, 0, 32'h00001C00, 32'h20000002, 32'h400000A4, 0, 0, 1);
        step(12, 0, NOP,   0, 1, 32'h00002149, 32'h00001C00, 32'h20000002, 1, 0, 1);
        step(13, 0, NOP,   1, 1, 32'h00002149, 32'h0,        32'h00001C00, 1, 0, 2);
        step(14, 0, NOP,   0, 1, 32'h00002149, 32'h0,        32'h0,        1, 0, 3);
        step(15, 0, NOP,   0, 0, 32'h00002149, 32'h0,        32'h0,        0, 0, 4);
        // flush with a valid decode instruction
        step(16, 0, ADD3,  0, 0, 32'h0,        32'h00002149, 32'h0,        0, 0, 4);
        step(17, 0, ADD11, 1, 0, 32'h00000C41, 32'h0,        32'h00002149, 0, 0, 4);
        // setx with fd_rd=7
        step(18, 0, SETX,  0, 0, 32'h0,        32'h00000C41, 32'h0,        0, 0, 4);
        step(19, 0, NOP,   0, 0, 32'h80007800, 32'h0,        32'h00000C41, 0, 0, 4);
        // long multdiv stall: saturates the 4-bit counter
        step(20, 0, NOP,   0, 1, 32'h0,        32'h80007800, 32'h0,        1, 0, 4);
        for (int j = 1; j <= 19; j++) begin
            step(20 + j, 0, NOP, 0, 1, 32'h0, 32'h0, (j == 1) ? 32'h80007800 : 32'h0, 1, 0, 4 + j);
        end
        step(40, 0, ADD3,  0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 24);
        step(41, 0, LW5,   0, 0, 32'h00000C41, 32'h0,        32'h0,        0, 0, 24);
        step(42, 0, ADD6,  0, 0, 32'h20001402, 32'h00000C41, 32'h0,        1, 1, 24);
        // reset asserted mid-cycle while md_busy stalls: immediate clear
        step(43, 1, ADD6,  0, 1, 32'h0,        32'h0,        32'h0,        1, 0, 0);
        step(44, 1, NOP,   0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0);
        step(45, 0, ADD3,  0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0);
        step(46, 0, NOP,   0, 0, 32'h00000C41, 32'h0,        32'h0,        0, 0, 0);

        repeat (3) @(posedge clock);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
